// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single lc3b memory port between I-fetch and D-access requesters.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MASK_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [MASK_W-1:0] d_byte_enable,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MASK_W-1:0] mem_byte_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [CNT_W-1:0]  i_xfer_count,
  output logic [CNT_W-1:0]  d_xfer_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       last_grant;
  logic       d_req_c;
  logic       grant_d_c;

  always_comb d_req_c = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention, favour whichever side was not served last.
  always_comb grant_d_c = (last_grant == GRANT_I);
`else
  always_comb grant_d_c = 1'b1;
  logic unused_last_grant;
  always_comb unused_last_grant = last_grant;
`endif

  // Read data is broadcast; it is only meaningful alongside the matching resp.
  always_comb i_rdata = mem_rdata;
  always_comb d_rdata = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_wdata       = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && d_req_c) begin
          next_state = grant_d_c ? SERVE_D : SERVE_I;
        end else if (d_req_c) begin
          next_state = SERVE_D;
        end else if (i_read) begin
          next_state = SERVE_I;
        end
      end
      SERVE_I: begin
        mem_read    = i_read;
        mem_address = i_address;
        i_resp      = mem_resp;
        if (mem_resp) next_state = IDLE;
      end
      SERVE_D: begin
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_address     = d_address;
        mem_byte_enable = d_byte_enable;
        mem_wdata       = d_wdata;
        d_resp          = mem_resp;
        if (mem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Completion bookkeeping: last served side and per-side transfer counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant   <= GRANT_I;
      i_xfer_count <= '0;
      d_xfer_count <= '0;
    end else if (mem_resp) begin
      if (state == SERVE_I) begin
        last_grant   <= GRANT_I;
        i_xfer_count <= i_xfer_count + CNT_W'(1);
      end else if (state == SERVE_D) begin
        last_grant   <= GRANT_D;
        d_xfer_count <= d_xfer_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: requester/memory models with a per-side scoreboard for mem_port_arbiter.
// Counters are instantiated 8 bits wide so the wrap case stays short.
module tb_mem_port_arbiter;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } job_t;

  logic             clk;
  logic             rst_n;
  logic             i_read;
  logic [15:0]      i_address;
  logic [15:0]      i_rdata;
  logic             i_resp;
  logic             d_read;
  logic             d_write;
  logic [1:0]       d_byte_enable;
  logic [15:0]      d_address;
  logic [15:0]      d_wdata;
  logic [15:0]      d_rdata;
  logic             d_resp;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_byte_enable;
  logic [15:0]      mem_address;
  logic [15:0]      mem_wdata;
  logic [15:0]      mem_rdata;
  logic             mem_resp;
  logic [CNT_W-1:0] i_xfer_count;
  logic [CNT_W-1:0] d_xfer_count;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .i_xfer_count(i_xfer_count), .d_xfer_count(d_xfer_count)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  job_t i_jobs[$];
  job_t d_jobs[$];
  job_t exp_i[$];
  job_t exp_d[$];
  logic glog[$];
  int   n_i = 0;
  int   n_d = 0;
  logic i_act = 1'b0, d_act = 1'b0, i_done = 1'b0, d_done = 1'b0;
  logic resp_m = 1'b0, resp_x = 1'b0;
  int   lat = 1;
  int   mcnt = 0;
  int   cyc = 0;
  int   last_resp_cyc = 0;
  logic resp_valid = 1'b0, prev_act = 1'b0, gap_en = 1'b0, log_en = 1'b0;

  function automatic logic [15:0] rd_fn(input logic [15:0] a);
    return a ^ 16'h1274;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_i(input logic [15:0] a);
    job_t j;
    j = '{rd: 1'b1, wr: 1'b0, addr: a, wdata: 16'h0, be: 2'b00};
    i_jobs.push_back(j);
    n_i++;
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be);
    job_t j;
    j = '{rd: rd, wr: wr, addr: a, wdata: wd, be: be};
    d_jobs.push_back(j);
    n_d++;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((i_jobs.size() != 0 || d_jobs.size() != 0 || i_act || d_act) && n < max_cyc) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= max_cyc) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge clk);
    #3;
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_resp  = resp_m | resp_x;
  assign mem_rdata = rd_fn(mem_address);

  // Memory model: answers an active strobe after lat cycles with a one-cycle resp.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_m = 1'b0;
      mcnt   = 0;
    end else if (resp_m) begin
      resp_m = 1'b0;
      mcnt   = 0;
    end else if (mem_read || mem_write) begin
      mcnt++;
      if (mcnt >= lat) resp_m = 1'b1;
    end else begin
      mcnt = 0;
    end
  end

  // Requesters: hold each request until its resp, then issue the next queued job.
  always @(posedge clk) begin
    job_t j;
    #1;
    if (rst_n) begin
      if (i_done) begin i_read = 1'b0; i_act = 1'b0; i_done = 1'b0; end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; d_act = 1'b0; d_done = 1'b0; end
      if (!i_act && i_jobs.size() != 0) begin
        j = i_jobs.pop_front();
        i_address = j.addr;
        i_read    = 1'b1;
        i_act     = 1'b1;
        exp_i.push_back(j);
      end
      if (!d_act && d_jobs.size() != 0) begin
        j = d_jobs.pop_front();
        d_address     = j.addr;
        d_wdata       = j.wdata;
        d_byte_enable = j.be;
        d_read        = j.rd;
        d_write       = j.wr;
        d_act         = 1'b1;
        exp_d.push_back(j);
      end
    end
  end

  // Monitor: pops the scoreboard on every resp and checks the port muxing.
  always @(negedge clk) begin
    job_t j;
    logic act;
    #2;
    cyc++;
    if (rst_n) begin
      act = mem_read | mem_write;
      if (gap_en && act && !prev_act && resp_valid) check("grant_gap", 32'(cyc - last_resp_cyc), 32'd2);
      if (resp_m) check("resp_fwd", {31'd0, i_resp | d_resp}, 32'd1);
      if (i_resp || d_resp) begin
        check("one_resp", {31'd0, i_resp & d_resp}, 32'd0);
        last_resp_cyc = cyc;
        resp_valid    = 1'b1;
        if (log_en) glog.push_back(d_resp);
      end
      if (i_resp) begin
        if (exp_i.size() == 0) check("i_unexpected", 32'd1, 32'd0);
        else begin
          j = exp_i.pop_front();
          check("i_addr", {16'd0, mem_address}, {16'd0, j.addr});
          check("i_port", {12'd0, mem_read, mem_write, mem_byte_enable, mem_wdata},
                {12'd0, 1'b1, 1'b0, 2'b00, 16'h0000});
          check("i_rdata", {16'd0, i_rdata}, {16'd0, rd_fn(j.addr)});
          i_done = 1'b1;
        end
      end
      if (d_resp) begin
        if (exp_d.size() == 0) check("d_unexpected", 32'd1, 32'd0);
        else begin
          j = exp_d.pop_front();
          check("d_addr", {16'd0, mem_address}, {16'd0, j.addr});
          check("d_port", {12'd0, mem_read, mem_write, mem_byte_enable, mem_wdata},
                {12'd0, j.rd & ~j.wr, j.wr, j.be, j.wdata});
          if (!j.wr) check("d_rdata", {16'd0, d_rdata}, {16'd0, rd_fn(j.addr)});
          d_done = 1'b1;
        end
      end
      prev_act = act;
    end
  end

  initial begin
    int n;
    logic exp_g;
    rst_n = 1'b0; i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_byte_enable = '0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {28'd0, mem_read, mem_write, i_resp, d_resp}, 32'd0);
    check("rst_counts", {16'd0, i_xfer_count, d_xfer_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #3;

    // Continuous contention from both sides.
    log_en = 1'b1; gap_en = 1'b1; resp_valid = 1'b0; lat = 1;
    for (int k = 0; k < 4; k++) begin
      push_i(16'h0100 + 16'(k));
      push_d(1'b1, 1'b0, 16'h0200 + 16'(k), 16'h0, 2'b01);
    end
    wait_idle(200);
    log_en = 1'b0; gap_en = 1'b0;
    check("grant_count", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0);
`else
      exp_g = (k < 4);
`endif
      check($sformatf("grant_order_%0d", k), {31'd0, glog[k]}, {31'd0, exp_g});
    end
    check("cnt_after_contention", {16'd0, i_xfer_count, d_xfer_count}, {16'd0, 8'd4, 8'd4});

    // Single instruction read with three-cycle memory latency.
    lat = 3;
    push_i(16'h0040);
    n = 0;
    while (!i_read && n < 10) begin @(posedge clk); #2; n++; end
    check("i_arb_lat0", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #2;
    check("i_arb_lat1", {15'd0, mem_read, mem_address}, {15'd0, 1'b1, 16'h0040});
    wait_idle(50);
    check("i_cnt_single", {24'd0, i_xfer_count}, 32'(n_i & 255));

    // Data write with both read and write asserted, then a plain data read.
    lat = 2;
    push_d(1'b1, 1'b1, 16'h8000, 16'hBEEF, 2'b10);
    push_d(1'b1, 1'b0, 16'h8002, 16'h0000, 2'b01);
    wait_idle(50);
    check("d_cnt_rw", {24'd0, d_xfer_count}, 32'(n_d & 255));

    // Stray mem_resp while idle.
    @(posedge clk); #1;
    resp_x = 1'b1;
    #1;
    check("idle_resp", {30'd0, i_resp, d_resp}, 32'd0);
    @(posedge clk); #1;
    resp_x = 1'b0;
    @(posedge clk); #2;
    check("idle_cnt", {16'd0, i_xfer_count, d_xfer_count}, {16'd0, 8'(n_i & 255), 8'(n_d & 255)});

    // Counter wrap on the data side.
    lat = 1;
    while ((n_d & 255) != 255) push_d(1'b1, 1'b0, 16'h3000 + 16'(n_d), 16'h0, 2'b00);
    wait_idle(2000);
    check("d_cnt_pre_wrap", {24'd0, d_xfer_count}, 32'd255);
    push_d(1'b0, 1'b1, 16'h3FFF, 16'h5555, 2'b11);
    wait_idle(50);
    check("d_cnt_wrap", {24'd0, d_xfer_count}, 32'd0);
    check("i_cnt_wrap", {24'd0, i_xfer_count}, 32'(n_i & 255));

    // Reset in the middle of a data write.
    lat = 20;
    push_d(1'b0, 1'b1, 16'h8010, 16'hCAFE, 2'b11);
    n = 0;
    while (!mem_write && n < 10) begin @(posedge clk); #2; n++; end
    check("pre_rst_write", {31'd0, mem_write}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_write_drop", {29'd0, mem_write, mem_read, d_resp}, 32'd0);
    check("rst_counts_mid", {16'd0, i_xfer_count, d_xfer_count}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_release_idle", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_release_dcnt", {24'd0, d_xfer_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single lc3b memory port (mem_read/mem_write/mem_resp handshake, 16-bit word, 2-bit byte mask) between an instruction-fetch requester and a data-access requester.
- Sits between the split I/D front end of the pipelined core and physical memory.
- Serialises the two requesters with a grant FSM, forwards data and responses, and counts completed transfers per side.

Parameters:
ADDR_W, 16, address width (lc3b_word)
DATA_W, 16, data width (lc3b_word)
MASK_W, 2, byte-enable width (lc3b_mem_wmask)
CNT_W, 16, width of transfer counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_read  in  1  instruction read request, held until i_resp
i_address  in  ADDR_W  instruction address
i_rdata  out  DATA_W  instruction read data
i_resp  out  1  instruction transfer complete
d_read  in  1  data read request, held until d_resp
d_write  in  1  data write request, held until d_resp
d_byte_enable  in  MASK_W  data write mask
d_address  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_rdata  out  DATA_W  data read data
d_resp  out  1  data transfer complete
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  MASK_W  memory write mask
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  memory transfer complete
i_xfer_count  out  CNT_W  completed instruction transfers
d_xfer_count  out  CNT_W  completed data transfers

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, last_grant=I, both counters=0. mem_read, mem_write, i_resp and d_resp are 0 while in reset. Any in-flight memory transaction is abandoned; requesters reissue after reset.
- States: IDLE, SERVE_I, SERVE_D (registered).
- IDLE:
  - No memory strobes are driven.
  - If exactly one side requests, go to its SERVE state on the next edge.
  - If both sides request, the priority rule applies (see Optional Feature).
  - If neither side requests, stay in IDLE.
  - mem_resp seen in IDLE is ignored and not forwarded.
- SERVE_I:
  - mem_read=i_read, mem_write=0, mem_address=i_address, mem_byte_enable=0, mem_wdata=0.
  - i_resp=mem_resp (combinational), d_resp=0.
- SERVE_D:
  - mem_read=d_read&~d_write and mem_write=d_write; d_write wins if both are asserted.
  - mem_address=d_address, mem_byte_enable=d_byte_enable, mem_wdata=d_wdata.
  - d_resp=mem_resp, i_resp=0.
- i_rdata and d_rdata both equal mem_rdata at all times; they are valid only alongside the respective resp.
- Leaving a SERVE state:
  - On mem_resp=1 in SERVE_x, next state=IDLE, last_grant<=x, and x_xfer_count increments.
  - Counters wrap 0xFFFF->0x0000.
  - Each transfer costs one IDLE bubble, so grant-to-grant spacing is at least latency+1 cycles.
- Latency: a request first seen in IDLE at edge k drives a mem strobe in the cycle after edge k (1 cycle of arbitration latency). Response forwarding adds 0 cycles.
- A requester dropping its request before resp is a protocol violation. The FSM stays in SERVE_x until mem_resp; the strobe follows the dropped request, so it goes low.
- No mem_resp ever: the FSM stays in SERVE_x indefinitely. There is no timeout.
- A new request on the non-granted side during SERVE is held off (its resp=0) and considered at the next IDLE.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in IDLE, grant the side not equal to last_grant (alternating I, D, I, D under continuous contention).
- Undefined: fixed priority, D always wins on simultaneous requests. last_grant is still maintained but unused.

Test Plan:
- Reset mid-SERVE_D (d_write=1, mem_write=1, rst_n pulsed low between edges) -> mem_write drops immediately, state=IDLE, d_xfer_count=0 after release.
- Single I read, i_address=0x0040, mem_resp after 3 cycles with mem_rdata=0x1234:
  - mem_read rises 1 cycle after i_read and mem_address=0x0040.
  - i_resp=1 with i_rdata=0x1234 in the same cycle as mem_resp.
  - i_xfer_count=1.
- D write with d_read=1 and d_write=1, d_address=0x8000, d_byte_enable=2'b10, d_wdata=0xBEEF:
  - mem_write=1, mem_read=0, mem_byte_enable=2'b10, mem_wdata=0xBEEF.
  - d_resp follows mem_resp.
- Simultaneous continuous i_read and d_read for 4 transfers:
  - Without ARB_ROUND_ROBIN_EN, the grant order is D,D,D,D.
  - With it defined, the order is D,I,D,I (last_grant=I out of reset).
  - Exactly one IDLE cycle between grants in both cases.
- mem_resp pulsed in IDLE with no requests -> i_resp=d_resp=0, counters unchanged.
- Counter wrap: preload via 65535 D transfers, then one more -> d_xfer_count=0x0000, i_xfer_count unchanged.
